uart_tx_frame: RTL and testbench

Parametrised UART transmitter and successor to the fixed 8N1 transmitter.
- Frame format configurable: data bits, parity mode, stop-bit count.
- Valid/ready input handshake with a one-entry holding register, so back-to-back frames go out with zero idle gap.
- Sits between a byte/word source (FIFO, CPU register) and the serial pin.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_tx_frame.sv | 209 ++++++++++++++++++++
 tb/tb_uart_tx_frame.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   - state_e     : one-hot frame-engine states
//   - PARITY_*    : parity mode encodings for the PARITY parameter
//   - clog2       : counter width helper (never returns less than 1)
//   - bit_clocks  : clocks per serial bit from clock frequency and line rate
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [4:0] {
    StIdle      = 5'b00001,
    StStartBit  = 5'b00010,
    StDataBits  = 5'b00100,
    StParityBit = 5'b01000,
    StStopBit   = 5'b10000
  } state_e;

  // Minimum width of 1 keeps single-value counters legal vectors.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    int unsigned reach;
    width = 0;
    reach = 1;
    while (reach < value) begin
      reach = reach << 1;
      width = width + 1;
    end
    if (width == 0) width = 1;
    return width;
  endfunction

  function automatic int unsigned bit_clocks(input int unsigned clk_khz,
                                             input int unsigned baud_bps);
    return (clk_khz * 1000) / baud_bps;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Ports:
//   i_clk      : system clock
//   i_rst      : asynchronous active-high reset
//   i_restart  : force the count back to 0 (aligns a new frame)
//   o_bit_end  : high while the count sits at BIT_CLOCKS-1; the count then wraps to 0
//   o_bit_pre  : high one cycle before o_bit_end, for registering end-of-bit outputs
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CLOCKS = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_bit_end,
  output logic o_bit_pre
);

  localparam int unsigned CntW = clog2(BIT_CLOCKS);
  localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CLOCKS - 1);
  localparam logic [CntW-1:0] PreCnt  = CntW'(BIT_CLOCKS - 2);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LastCnt)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bit_end = (r_cnt == LastCnt);
  assign o_bit_pre = (r_cnt == PreCnt);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-entry holding register.
// Ports:
//   i_clk         : system clock, rising edge
//   i_rst         : asynchronous active-high reset; aborts any frame in flight
//   i_data_valid  : source offers i_data this cycle
//   o_data_ready  : holding register empty; transfer on i_data_valid && o_data_ready
//   i_data        : payload, LSB transmitted first
//   o_tx          : serial line, idle high
//   o_tx_en       : high while any frame bit is on the line
//   o_tx_done     : one-cycle pulse on the last cycle of each frame's final stop bit
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_KHz  = 50000,
  parameter int unsigned BAUD_RATE_BPS = 115200,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = PARITY_NONE,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned BIT_CLOCKS    = bit_clocks(CLK_FREQ_KHz, BAUD_RATE_BPS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_data_valid,
  output logic                 o_data_ready,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_tx,
  output logic                 o_tx_en,
  output logic                 o_tx_done
);

  if (BIT_CLOCKS < 2) begin : g_bad_bit_clocks
    $error("uart_tx_frame: BIT_CLOCKS must be at least 2");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be within 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  localparam int unsigned DcntW = clog2(DATA_BITS);
  localparam logic [DcntW-1:0] DataLast = DcntW'(DATA_BITS - 1);
  localparam logic             StopLast = 1'(STOP_BITS - 1);

  state_e               r_state, w_state_d;
  logic [DATA_BITS-1:0] r_shift, w_shift_d;
  logic                 r_parity, w_parity_d;
  logic [DcntW-1:0]     r_dcnt, w_dcnt_d;
  logic                 r_scnt, w_scnt_d;
  logic [DATA_BITS-1:0] r_hold_data, w_hold_data_d;
  logic                 r_hold_full, w_hold_full_d;
  logic                 r_data_ready, w_data_ready_d;
  logic                 r_tx, w_tx_d;
  logic                 r_tx_en, w_tx_en_d;
  logic                 r_tx_done, w_tx_done_d;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_bit_pre;

  uart_bit_timer #(
    .BIT_CLOCKS (BIT_CLOCKS)
  ) u_bit_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_restart (w_load),
    .o_bit_end (w_bit_end),
    .o_bit_pre (w_bit_pre)
  );

  // Frame engine: every output is registered, so each branch sets the value the line
  // must carry from the next cycle on.
  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_parity_d  = r_parity;
    w_dcnt_d    = r_dcnt;
    w_scnt_d    = r_scnt;
    w_tx_d      = r_tx;
    w_tx_en_d   = r_tx_en;
    w_tx_done_d = 1'b0;
    w_load      = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_tx_d    = 1'b1;
        w_tx_en_d = 1'b0;
        w_load    = r_hold_full;
      end
      StStartBit: begin
        if (w_bit_end) begin
          w_state_d = StDataBits;
          w_tx_d    = r_shift[0];
        end
      end
      StDataBits: begin
        if (w_bit_end) begin
          w_shift_d = r_shift >> 1;
          if (r_dcnt == DataLast) begin
            w_dcnt_d = '0;
            if (PARITY != PARITY_NONE) begin
              w_state_d = StParityBit;
              w_tx_d    = r_parity;
            end else begin
              w_state_d = StStopBit;
              w_tx_d    = 1'b1;
            end
          end else begin
            w_dcnt_d = r_dcnt + 1'b1;
            w_tx_d   = r_shift[1];
          end
        end
      end
      StParityBit: begin
        if (w_bit_end) begin
          w_state_d = StStopBit;
          w_tx_d    = 1'b1;
        end
      end
      StStopBit: begin
        // Registered pulse: raise it one cycle early so it lands on the final cycle.
        if ((r_scnt == StopLast) && w_bit_pre) begin
          w_tx_done_d = 1'b1;
        end
        if (w_bit_end) begin
          if (r_scnt == StopLast) begin
            w_scnt_d = 1'b0;
            if (r_hold_full) begin
              w_load = 1'b1;
            end else begin
              w_state_d = StIdle;
              w_tx_d    = 1'b1;
              w_tx_en_d = 1'b0;
            end
          end else begin
            w_scnt_d = r_scnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_tx_d    = 1'b1;
        w_tx_en_d = 1'b0;
      end
    endcase

    if (w_load) begin
      w_state_d  = StStartBit;
      w_shift_d  = r_hold_data;
      w_parity_d = (PARITY == PARITY_ODD) ? ~(^r_hold_data) : (^r_hold_data);
      w_dcnt_d   = '0;
      w_scnt_d   = 1'b0;
      w_tx_d     = 1'b0;
      w_tx_en_d  = 1'b1;
    end
  end

  // Holding register: an accept on the same edge as a load refills it immediately.
  always_comb begin
    w_accept       = i_data_valid && r_data_ready;
    w_hold_data_d  = r_hold_data;
    w_hold_full_d  = r_hold_full;
    if (w_load) begin
      w_hold_full_d = 1'b0;
    end
    if (w_accept) begin
      w_hold_data_d = i_data;
      w_hold_full_d = 1'b1;
    end
    w_data_ready_d = ~w_hold_full_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_dcnt       <= '0;
      r_scnt       <= 1'b0;
      r_hold_data  <= '0;
      r_hold_full  <= 1'b0;
      r_data_ready <= 1'b1;
      r_tx         <= 1'b1;
      r_tx_en      <= 1'b0;
      r_tx_done    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_shift      <= w_shift_d;
      r_parity     <= w_parity_d;
      r_dcnt       <= w_dcnt_d;
      r_scnt       <= w_scnt_d;
      r_hold_data  <= w_hold_data_d;
      r_hold_full  <= w_hold_full_d;
      r_data_ready <= w_data_ready_d;
      r_tx         <= w_tx_d;
      r_tx_en      <= w_tx_en_d;
      r_tx_done    <= w_tx_done_d;
    end
  end

  assign o_data_ready = r_data_ready;
  assign o_tx         = r_tx;
  assign o_tx_en      = r_tx_en;
  assign o_tx_done    = r_tx_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame. Four instances (8N1, 7E1, 7O1, 8N2) at
// BIT_CLOCKS = 10. Stimulus pushes the expected word at each accept edge; the monitor
// watches every serial line, pops on each start bit and checks the frame cycle by cycle.
module tb_uart_tx_frame;

  localparam int NI = 4;
  localparam int BC = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid   [NI];
  logic [7:0] din     [NI];
  logic       ready   [NI];
  logic       tx      [NI];
  logic       tx_en   [NI];
  logic       tx_done [NI];

  int nb [NI] = '{8, 7, 7, 8};
  int pm [NI] = '{0, 2, 1, 0};
  int ns [NI] = '{1, 1, 1, 2};

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       pbit;
    bit         abort;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   idle_bad = 0;
  bit   mon_busy = 1'b0;
  int   prev_done [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_frame #(
    .CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_8n1 (
    .i_clk(clk), .i_rst(rst), .i_data_valid(valid[0]), .o_data_ready(ready[0]),
    .i_data(din[0]), .o_tx(tx[0]), .o_tx_en(tx_en[0]), .o_tx_done(tx_done[0])
  );

  uart_tx_frame #(
    .CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
  ) u_7e1 (
    .i_clk(clk), .i_rst(rst), .i_data_valid(valid[1]), .o_data_ready(ready[1]),
    .i_data(din[1][6:0]), .o_tx(tx[1]), .o_tx_en(tx_en[1]), .o_tx_done(tx_done[1])
  );

  uart_tx_frame #(
    .CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(100000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)
  ) u_7o1 (
    .i_clk(clk), .i_rst(rst), .i_data_valid(valid[2]), .o_data_ready(ready[2]),
    .i_data(din[2][6:0]), .o_tx(tx[2]), .o_tx_en(tx_en[2]), .o_tx_done(tx_done[2])
  );

  uart_tx_frame #(
    .CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)
  ) u_8n2 (
    .i_clk(clk), .i_rst(rst), .i_data_valid(valid[3]), .o_data_ready(ready[3]),
    .i_data(din[3]), .o_tx(tx[3]), .o_tx_en(tx_en[3]), .o_tx_done(tx_done[3])
  );

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Called at a falling edge; holds valid until ready, records the accept cycle.
  task automatic send(input int inst, input logic [7:0] d, input logic pbit, input bit abort,
                      output int acc);
    int n;
    n = 0;
    valid[inst] = 1'b1;
    din[inst]   = d;
    while (ready[inst] !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (n >= 1000) chk("send_timeout", n, 0);
    else exp_q.push_back('{inst: inst, data: d, pbit: pbit, abort: abort, acc: cyc});
    @(negedge clk);
    valid[inst] = 1'b0;
    chk("ready_fall", ready[inst], 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 3000) chk("drain_timeout", n, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t       cur;
    int         ci, k, flen, bad_k, b, t0;
    logic       eb, ed;
    logic [2:0] bad_got, bad_req;
    logic [7:0] rx;
    logic       rxp;
    ci = 0; k = 0; flen = 0; bad_k = -1; b = 0; t0 = 0;
    eb = 1'b1; ed = 1'b0; bad_got = '0; bad_req = '0; rx = '0; rxp = 1'b0;
    cur = '{inst: 0, data: 8'h00, pbit: 1'b0, abort: 1'b0, acc: 0};
    for (int j = 0; j < NI; j++) prev_done[j] = -1000;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        if (mon_busy) begin
          checks++;
          if (!cur.abort || bad_k >= 0) begin
            errors++;
            $display("FAIL abort inst %0d: planned=%0b first_bad_cycle=%0d, required planned=1 first_bad_cycle=-1",
                     ci, cur.abort, bad_k);
          end
          mon_busy = 1'b0;
        end
        for (int j = 0; j < NI; j++) prev_done[j] = -1000;
      end else begin
        if (!mon_busy) begin
          for (int j = 0; j < NI; j++) begin
            if (!mon_busy && tx[j] === 1'b0) begin
              mon_busy = 1'b1;
              ci = j; k = 0; bad_k = -1; rx = '0; rxp = 1'b0;
              flen = (1 + nb[j] + ((pm[j] != 0) ? 1 : 0) + ns[j]) * BC;
              if (exp_q.size() == 0) begin
                cur = '{inst: j, data: 8'h00, pbit: 1'b0, abort: 1'b0, acc: cyc - 2};
                checks++;
                errors++;
                $display("FAIL unexpected_frame inst %0d: got a start bit at cycle %0d, required none",
                         j, cyc);
              end else begin
                cur = exp_q.pop_front();
                t0 = (cur.acc + 2 > prev_done[j] + 1) ? cur.acc + 2 : prev_done[j] + 1;
                chk("frame_instance", j, cur.inst);
                chk("start_cycle", cyc, t0);
              end
            end
          end
        end
        for (int j = 0; j < NI; j++) begin
          if (!(mon_busy && j == ci) &&
              (tx[j] !== 1'b1 || tx_en[j] !== 1'b0 || tx_done[j] !== 1'b0)) idle_bad++;
        end
        if (mon_busy) begin
          b = k / BC;
          if (b == 0) eb = 1'b0;
          else if (b <= nb[ci]) eb = cur.data[b-1];
          else if (pm[ci] != 0 && b == nb[ci] + 1) eb = cur.pbit;
          else eb = 1'b1;
          ed = (k == flen - 1);
          if (bad_k < 0 && {tx[ci], tx_en[ci], tx_done[ci]} !== {eb, 1'b1, ed}) begin
            bad_k   = k;
            bad_got = {tx[ci], tx_en[ci], tx_done[ci]};
            bad_req = {eb, 1'b1, ed};
          end
          if (k % BC == BC / 2) begin
            if (b >= 1 && b <= nb[ci]) rx[b-1] = tx[ci];
            else if (pm[ci] != 0 && b == nb[ci] + 1) rxp = tx[ci];
          end
          k++;
          if (k == flen) begin
            checks++;
            if (bad_k >= 0) begin
              errors++;
              $display("FAIL frame_wave inst %0d data 0x%02h: frame cycle %0d got {tx,tx_en,tx_done}=%03b, required %03b",
                       ci, cur.data, bad_k, bad_got, bad_req);
            end
            chk("frame_data", rx, cur.data);
            if (pm[ci] != 0) chk("frame_parity", rxp, cur.pbit);
            prev_done[ci] = cyc;
            mon_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin : stim
    int a, a2, b, g, n_acc;
    a = 0; a2 = 0; b = 0; g = 0; n_acc = 0;
    rst = 1'b0;
    for (int j = 0; j < NI; j++) begin
      valid[j] = 1'b0;
      din[j]   = '0;
    end
    #2 rst = 1'b1;
    #2;
    for (int j = 0; j < NI; j++) chk("reset_state", {tx[j], tx_en[j], tx_done[j], ready[j]}, 4'b1001);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Basic 8N1.
    send(0, 8'h55, 1'b0, 1'b0, a);
    wait_idle();

    // 7 data bits, 0x03 has two ones: even parity bit 0, odd parity bit 1.
    send(1, 8'h03, 1'b0, 1'b0, a);
    wait_idle();
    send(2, 8'h03, 1'b1, 1'b0, a);
    wait_idle();

    // Two stop bits; second word accepted on the final stop cycle gets one idle cycle.
    send(3, 8'hFF, 1'b0, 1'b0, a);
    while (cyc < a + 111) @(negedge clk);
    send(3, 8'h12, 1'b0, 1'b0, b);
    chk("accept_at_done", b, a + 111);
    wait_idle();

    // Back-to-back with valid held high.
    send(0, 8'hA5, 1'b0, 1'b0, a);
    send(0, 8'h3C, 1'b0, 1'b0, a2);
    chk("second_accept", a2, a + 2);
    while (cyc < a + 101) @(negedge clk);
    chk("ready_held_low", ready[0], 0);
    @(negedge clk);
    chk("ready_after_load", ready[0], 1);
    wait_idle();

    // Reset in the middle of the data bits.
    send(0, 8'h5A, 1'b0, 1'b1, a);
    while (cyc < a + 40) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_async", {tx[0], tx_en[0], tx_done[0], ready[0]}, 4'b1001);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    send(0, 8'h81, 1'b0, 1'b0, a);
    wait_idle();

    // Valid held with data changing every cycle; only accept-edge values are expected.
    valid[0] = 1'b1;
    g = 0;
    n_acc = 0;
    while (n_acc < 3 && g < 1000) begin
      din[0] = 8'h3C ^ 8'(g * 23);
      if (ready[0] === 1'b1) begin
        exp_q.push_back('{inst: 0, data: din[0], pbit: 1'b0, abort: 1'b0, acc: cyc});
        n_acc++;
      end
      @(negedge clk);
      g++;
    end
    valid[0] = 1'b0;
    if (g >= 1000) chk("stream_timeout", n_acc, 3);
    wait_idle();

    chk("queue_empty", exp_q.size(), 0);
    chk("idle_glitches", idle_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
